// File: rtl/ram_bank.sv
// ram_bank: byte-addressed data RAM bank for the load/store path.
// It takes requests through a valid/ready handshake and returns one response
// strobe LATENCY cycles after each accepted request. Faulting accesses
// (out of range, misaligned, illegal size) touch no memory and return err=1.
module ram_bank #(
  parameter logic [31:0] BASE    = 32'h0000_0400,
  parameter int          DEPTH   = 256,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH);
  // 33-bit limit so BASE + 4*DEPTH cannot wrap at the top of the address map
  localparam logic [32:0] LIMIT    = {1'b0, BASE} + 33'(4 * DEPTH);
  localparam logic [1:0]  CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic          accept;
  logic          in_range, misaligned, req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_sel, lane_we;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word, rd_shifted, load_data;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;
  logic [31:0]   pend_rdata_reg, resp_rdata_reg;
  logic          pend_err_reg, resp_err_reg;

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state_reg != WAIT);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

  assign in_range   = ({1'b0, req_addr} >= {1'b0, BASE}) && ({1'b0, req_addr} < LIMIT);
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign req_err    = !in_range || misaligned || (req_size == 2'd3);
  assign word_idx   = req_addr[AW+1:2];

  // Byte-lane selection and right-aligned store data replicated onto every lane
  always_comb begin
    lane_sel  = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        lane_sel  = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_sel  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2: lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
    lane_we = (accept && req_write && !req_err) ? lane_sel : 4'b0000;
  end

  // One byte-wide array per lane so partial stores need no read-modify-write
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      // Lane write on the accept edge; contents survive reset
      always_ff @(posedge clk) begin
        if (lane_we[gi]) mem[word_idx] <= wdata_rep[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = mem[word_idx];
    end
  endgenerate

  assign rd_shifted = rd_word >> {req_addr[1:0], 3'b000};
  assign byte_val   = rd_shifted[7:0];
  assign half_val   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Lane extraction and sign/zero extension of the word being read
  always_comb begin
    load_data = 32'h0;
    case (req_size)
      2'd0:    load_data = {{24{!req_unsigned && byte_val[7]}}, byte_val};
      2'd1:    load_data = {{16{!req_unsigned && half_val[15]}}, half_val};
      2'd2:    load_data = rd_word;
      default: load_data = 32'h0;
    endcase
    if (req_write || req_err) load_data = 32'h0;
  end

  // Next-state logic: RESP behaves like IDLE for a new request
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == 2'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Parked result of an accepted request while it waits out the latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rdata_reg <= 32'h0;
      pend_err_reg   <= 1'b0;
    end else if (accept) begin
      pend_rdata_reg <= load_data;
      pend_err_reg   <= req_err;
    end
  end

  // Response registers change only when a response is issued, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else if (accept && (LATENCY == 1)) begin
      resp_rdata_reg <= load_data;
      resp_err_reg   <= req_err;
    end else if ((state_reg == WAIT) && (cnt_reg == 2'd0)) begin
      resp_rdata_reg <= pend_rdata_reg;
      resp_err_reg   <= pend_err_reg;
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives a LATENCY=1 and a LATENCY=3 bank and compares every
// response with a byte-array reference model of the memory.
module tb_ram_bank;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DEPTH = 256;
  localparam int          NB    = 4 * DEPTH;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] wd;
    logic        eerr;
    logic [31:0] erd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        valid1, ready1, rv1, er1;
  logic [31:0] rd1;
  logic        valid3, ready3, rv3, er3;
  logic [31:0] rd3;

  int checks = 0;
  int passes = 0;

  // Reference memory: one byte array per bank instance (0 -> L1, 1 -> L3)
  logic [7:0] mm [2][NB];

  always #5 clk = ~clk;

  ram_bank #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
  );

  ram_bank #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3)
  );

  // Access of n = 2^sz bytes at a; loads gather bytes little-endian and extend
  function automatic void model_access(input int w, input bit wr, input logic [31:0] a,
                                       input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                                       output logic eerr, output logic [31:0] erd);
    int n, off, mi;
    logic [31:0] v;
    mi   = (w == 1) ? 0 : 1;
    n    = 1 << sz;
    erd  = 32'h0;
    eerr = (sz == 2'd3) || (a < BASE) || (a >= BASE + NB) || ((a % n) != 0);
    if (eerr) return;
    off = int'(a - BASE);
    if (wr) begin
      for (int i = 0; i < n; i++) mm[mi][off+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[mi][off+i];
      if (!uns && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      erd = v;
    end
  endfunction

  function automatic op_t mk(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                             input bit uns, input logic [31:0] wd, input logic eerr,
                             input logic [31:0] erd);
    op_t o;
    o.wr = wr; o.a = a; o.sz = sz; o.uns = uns; o.wd = wd; o.eerr = eerr; o.erd = erd;
    return o;
  endfunction

  // Mostly small in-range window (so loads hit earlier stores), some boundary probes
  function automatic op_t rand_op(input int win);
    op_t o;
    int  r;
    o.wr = 1'($urandom_range(0, 1));
    r    = int'($urandom_range(0, 9));
    case (r)
      0:       o.a = BASE - 32'($urandom_range(1, 4));
      1:       o.a = BASE + NB + 32'($urandom_range(0, 7));
      2:       o.a = BASE + NB - 32'($urandom_range(1, 4));
      default: o.a = BASE + 32'($urandom_range(0, win - 1));
    endcase
    o.sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    o.uns  = 1'($urandom_range(0, 1));
    o.wd   = $urandom();
    o.eerr = 1'b0;
    o.erd  = 32'h0;
    return o;
  endfunction

  task automatic drive_bus(input op_t o);
    req_write    = o.wr;
    req_addr     = o.a;
    req_size     = o.sz;
    req_unsigned = o.uns;
    req_wdata    = o.wd;
  endtask

  // One request on instance w; returns response fields and cycles from accept to resp_valid
  task automatic do_op(input int w, input op_t o, input bit quiet,
                       output logic oerr, output logic [31:0] ord, output int olat);
    int guard;
    oerr  = 1'bx;
    ord   = 'x;
    olat  = -1;
    guard = 0;
    @(negedge clk);
    drive_bus(o);
    while (((w == 1) ? ready1 : ready3) !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      $display("do_op: L%0d instance never raised req_ready", w);
      return;
    end
    if (w == 1) valid1 = 1'b1; else valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (((w == 1) ? rv1 : rv3) === 1'b1) begin
        olat = k;
        oerr = (w == 1) ? er1 : er3;
        ord  = (w == 1) ? rd1 : rd3;
        break;
      end
    end
    if (!quiet)
      $display("L%0d %s addr=%h size=%0d uns=%0d wdata=%h -> err=%0d rdata=%h lat=%0d",
               w, o.wr ? "ST" : "LD", o.a, o.sz, o.uns, o.wd, oerr, ord, olat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ready1, rv1, rd1, er1} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      $display("FAIL reset_l1 got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", ready1, rv1, rd1, er1);
    end else passes++;
    checks++;
    if ({ready3, rv3, rd3, er3} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      $display("FAIL reset_l3 got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", ready3, rv3, rd3, er3);
    end else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready1, rv1, ready3, rv3} !== 4'b1010) begin
      $display("FAIL post_reset idle got ready1=%b rv1=%b ready3=%b rv3=%b want 1 0 1 0", ready1, rv1, ready3, rv3);
    end else passes++;
  endtask

  // Bring both banks and the model to an all-zero state
  task automatic clear_mem();
    logic oe, ee;
    logic [31:0] od, er;
    int ol;
    for (int w = 1; w <= 3; w += 2)
      for (int i = 0; i < DEPTH; i++) begin
        model_access(w, 1'b1, BASE + 32'(4*i), 2'd2, 1'b0, 32'h0, ee, er);
        do_op(w, mk(1'b1, BASE + 32'(4*i), 2'd2, 1'b0, 32'h0, 1'b0, 32'h0), 1'b1, oe, od, ol);
      end
  endtask

  task automatic test_directed();
    op_t q[$];
    logic oe, ee;
    logic [31:0] od, er;
    int ol;
    q.push_back(mk(1, 32'h400, 2, 0, 32'hDEADBEEF, 0, 32'h0));
    q.push_back(mk(0, 32'h400, 2, 0, 32'h0,        0, 32'hDEADBEEF));
    q.push_back(mk(1, 32'h405, 0, 0, 32'h80,       0, 32'h0));
    q.push_back(mk(0, 32'h405, 0, 0, 32'h0,        0, 32'hFFFFFF80));
    q.push_back(mk(0, 32'h405, 0, 1, 32'h0,        0, 32'h00000080));
    q.push_back(mk(0, 32'h404, 2, 0, 32'h0,        0, 32'h00008000));
    q.push_back(mk(1, 32'h406, 0, 0, 32'hAAAAAA7F, 0, 32'h0));
    q.push_back(mk(0, 32'h404, 2, 0, 32'h0,        0, 32'h007F8000));
    q.push_back(mk(1, 32'h40A, 1, 0, 32'h1234,     0, 32'h0));
    q.push_back(mk(0, 32'h40A, 1, 0, 32'h0,        0, 32'h00001234));
    q.push_back(mk(0, 32'h409, 1, 0, 32'h0,        1, 32'h0));
    q.push_back(mk(0, 32'h408, 2, 0, 32'h0,        0, 32'h12340000));
    q.push_back(mk(1, 32'h40E, 1, 0, 32'hFFFF8001, 0, 32'h0));
    q.push_back(mk(0, 32'h40E, 1, 0, 32'h0,        0, 32'hFFFF8001));
    q.push_back(mk(0, 32'h40E, 1, 1, 32'h0,        0, 32'h00008001));
    q.push_back(mk(0, 32'h40C, 2, 0, 32'h0,        0, 32'h80010000));
    q.push_back(mk(1, 32'h3FC, 2, 0, 32'h11111111, 1, 32'h0));
    q.push_back(mk(1, 32'h800, 2, 0, 32'h11111111, 1, 32'h0));
    q.push_back(mk(0, 32'h7FC, 2, 0, 32'h0,        0, 32'h0));
    q.push_back(mk(0, 32'h400, 3, 0, 32'h0,        1, 32'h0));
    q.push_back(mk(1, 32'h400, 3, 0, 32'hFFFFFFFF, 1, 32'h0));
    q.push_back(mk(1, 32'h402, 2, 0, 32'h55555555, 1, 32'h0));
    q.push_back(mk(0, 32'h400, 2, 0, 32'h0,        0, 32'hDEADBEEF));
    foreach (q[i]) begin
      model_access(1, q[i].wr, q[i].a, q[i].sz, q[i].uns, q[i].wd, ee, er);
      do_op(1, q[i], 1'b0, oe, od, ol);
      checks++;
      if (oe !== q[i].eerr || od !== q[i].erd || ol != 1) begin
        $display("FAIL directed[%0d] got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=1",
                 i, oe, od, ol, q[i].eerr, q[i].erd);
      end else passes++;
    end
  endtask

  task automatic test_back_to_back();
    op_t cur;
    logic ee;
    logic [31:0] er;
    cur = rand_op(32);
    model_access(1, cur.wr, cur.a, cur.sz, cur.uns, cur.wd, ee, er);
    @(negedge clk);
    drive_bus(cur);
    valid1 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (rv1 !== 1'b1 || ready1 !== 1'b1 || er1 !== ee || rd1 !== er) begin
        $display("FAIL b2b[%0d] got valid=%b ready=%b err=%b rdata=%h want 1 1 err=%b rdata=%h",
                 i, rv1, ready1, er1, rd1, ee, er);
      end else passes++;
      $display("L1 b2b %s addr=%h size=%0d uns=%0d wdata=%h -> err=%b rdata=%h",
               cur.wr ? "ST" : "LD", cur.a, cur.sz, cur.uns, cur.wd, er1, rd1);
      if (i < 79) begin
        cur = rand_op(32);
        model_access(1, cur.wr, cur.a, cur.sz, cur.uns, cur.wd, ee, er);
        drive_bus(cur);
      end else begin
        valid1 = 1'b0;
      end
    end
  endtask

  task automatic test_random_lat3();
    op_t o;
    logic oe, ee;
    logic [31:0] od, er;
    int ol;
    for (int i = 0; i < 40; i++) begin
      o = rand_op(32);
      model_access(3, o.wr, o.a, o.sz, o.uns, o.wd, ee, er);
      do_op(3, o, 1'b0, oe, od, ol);
      checks++;
      if (oe !== ee || od !== er || ol != 3) begin
        $display("FAIL rand_l3[%0d] got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=3",
                 i, oe, od, ol, ee, er);
      end else passes++;
    end
  endtask

  task automatic test_latency3();
    op_t sa, la, lb;
    logic oe, ee, ea, eb;
    logic [31:0] od, er, ra, rb;
    int ol;
    sa = mk(1, 32'h430, 2, 0, 32'h0BADF00D, 0, 32'h0);
    la = mk(0, 32'h430, 2, 0, 32'h0, 0, 32'h0);
    lb = mk(0, 32'h433, 0, 1, 32'h0, 0, 32'h0);
    model_access(3, sa.wr, sa.a, sa.sz, sa.uns, sa.wd, ee, er);
    do_op(3, sa, 1'b0, oe, od, ol);
    checks++;
    if (oe !== ee || od !== er || ol != 3) begin
      $display("FAIL lat3_store got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=3", oe, od, ol, ee, er);
    end else passes++;
    model_access(3, la.wr, la.a, la.sz, la.uns, la.wd, ea, ra);
    model_access(3, lb.wr, lb.a, lb.sz, lb.uns, lb.wd, eb, rb);
    @(negedge clk);
    drive_bus(la);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    drive_bus(lb);
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b0 || rv3 !== 1'b0 || rd3 !== 32'h0) begin
      $display("FAIL lat3_a_c1 got ready=%b valid=%b rdata=%h want 0 0 00000000", ready3, rv3, rd3);
    end else passes++;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b0 || rv3 !== 1'b0) begin
      $display("FAIL lat3_a_c2 got ready=%b valid=%b want 0 0", ready3, rv3);
    end else passes++;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b1 || rv3 !== 1'b1 || er3 !== ea || rd3 !== ra) begin
      $display("FAIL lat3_a_resp got ready=%b valid=%b err=%b rdata=%h want 1 1 err=%b rdata=%h",
               ready3, rv3, er3, rd3, ea, ra);
    end else passes++;
    $display("L3 LD addr=%h -> err=%b rdata=%h", la.a, er3, rd3);
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b0 || rv3 !== 1'b0 || rd3 !== ra) begin
      $display("FAIL lat3_b_c1 got ready=%b valid=%b rdata=%h want 0 0 %h", ready3, rv3, rd3, ra);
    end else passes++;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b0 || rv3 !== 1'b0) begin
      $display("FAIL lat3_b_c2 got ready=%b valid=%b want 0 0", ready3, rv3);
    end else passes++;
    @(negedge clk);
    checks++;
    if (ready3 !== 1'b1 || rv3 !== 1'b1 || er3 !== eb || rd3 !== rb) begin
      $display("FAIL lat3_b_resp got ready=%b valid=%b err=%b rdata=%h want 1 1 err=%b rdata=%h",
               ready3, rv3, er3, rd3, eb, rb);
    end else passes++;
    $display("L3 LD addr=%h -> err=%b rdata=%h", lb.a, er3, rd3);
  endtask

  task automatic test_reset_midop();
    op_t st, ld;
    logic oe, ee;
    logic [31:0] od, er;
    int ol, bad;
    st = mk(1, 32'h440, 2, 0, 32'hCAFE1234, 0, 32'h0);
    ld = mk(0, 32'h440, 2, 0, 32'h0, 0, 32'h0);
    model_access(3, st.wr, st.a, st.sz, st.uns, st.wd, ee, er);
    do_op(3, st, 1'b0, oe, od, ol);
    checks++;
    if (oe !== ee || od !== er || ol != 3) begin
      $display("FAIL midrst_store got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=3", oe, od, ol, ee, er);
    end else passes++;
    @(negedge clk);
    drive_bus(ld);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv3 !== 1'b0 || ready3 !== 1'b1 || rd3 !== 32'h0) bad++;
      if (k == 1) rst_n = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL midrst_drop got %0d bad cycles (valid=%b ready=%b rdata=%h) want 0", bad, rv3, ready3, rd3);
    end else passes++;
    $display("L3 LD addr=%h dropped by reset", ld.a);
    model_access(3, ld.wr, ld.a, ld.sz, ld.uns, ld.wd, ee, er);
    do_op(3, ld, 1'b0, oe, od, ol);
    checks++;
    if (oe !== ee || od !== er || ol != 3) begin
      $display("FAIL midrst_reload got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=3", oe, od, ol, ee, er);
    end else passes++;
  endtask

  initial begin
    valid1       = 1'b0;
    valid3       = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    test_reset();
    clear_mem();
    test_directed();
    test_back_to_back();
    test_random_lat3();
    test_latency3();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
